// File: rtl/fir_pkg.sv
// Shared types and default widths for the FIR window MAC slice.
package fir_pkg;

  localparam int DEF_DATA_W = 11;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_N_TAPS = 16;
  localparam int DEF_IDX_W  = 4;
  localparam int DEF_ACC_W  = DEF_DATA_W + DEF_COEF_W + 4;

  // Unity coefficients make the out-of-reset operation a plain boxcar sum.
  localparam logic signed [DEF_COEF_W-1:0] COEF_RST = 8'sd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic signed [DEF_DATA_W-1:0] lane_sel(
    input logic [DEF_N_TAPS*DEF_DATA_W-1:0] win,
    input logic [DEF_IDX_W-1:0]             idx
  );
    return win[idx*DEF_DATA_W +: DEF_DATA_W];
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: synchronous write blocked while busy, asynchronous read.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int COEF_W = DEF_COEF_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic                     i_busy,
  input  logic [IDX_W-1:0]         i_waddr,
  input  logic [COEF_W-1:0]        i_wdata,
  input  logic [IDX_W-1:0]         i_raddr,
  output logic signed [COEF_W-1:0] o_rdata
);

  logic signed [COEF_W-1:0] r_coef [N_TAPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_TAPS; k++) begin
        r_coef[k] <= COEF_RST;
      end
    end else if (i_we && !i_busy) begin
      r_coef[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_coef[i_raddr];

endmodule

// File: rtl/fir_window_mac.sv
// Drains a full sample window from the FIFO and computes a 16-tap signed dot product, one tap per clock.
module fir_window_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int COEF_W = DEF_COEF_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fifo_ready,
  input  logic [N_TAPS*DATA_W-1:0]     fifo_data,
  output logic                         fifo_read,
  input  logic                         coef_we,
  input  logic [3:0]                   coef_addr,
  input  logic [COEF_W-1:0]            coef_wdata,
  output logic                         coef_busy,
  output logic signed [DATA_W+COEF_W+3:0] result,
  output logic                         result_valid,
  input  logic                         result_ack
);

  localparam int ACC_W  = DATA_W + COEF_W + 4;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int IDX_W  = 4;

  state_t                     r_state;
  logic [N_TAPS*DATA_W-1:0]   r_window;
  logic [IDX_W-1:0]           r_idx;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    r_result;
  logic                       r_valid;

  logic signed [DATA_W-1:0]   w_sample;
  logic signed [COEF_W-1:0]   w_coef;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_sum;

  fir_coef_bank #(
    .N_TAPS (N_TAPS),
    .COEF_W (COEF_W),
    .IDX_W  (IDX_W)
  ) u_coef_bank (
    .clk     (clk),
    .reset   (reset),
    .i_we    (coef_we),
    .i_busy  (coef_busy),
    .i_waddr (coef_addr),
    .i_wdata (coef_wdata),
    .i_raddr (r_idx),
    .o_rdata (w_coef)
  );

  // 16 products of at most 2^17 magnitude fit in ACC_W, so the sum never wraps.
  assign w_sample = lane_sel(r_window, r_idx);
  assign w_prod   = w_sample * w_coef;
  assign w_sum    = r_acc + ACC_W'(w_prod);

  assign fifo_read    = (r_state == ST_IDLE) && fifo_ready;
  assign coef_busy    = (r_state == ST_MAC);
  assign result       = r_result;
  assign result_valid = r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_window <= '0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fifo_ready) begin
            r_window <= fifo_data;
            r_acc    <= '0;
            r_idx    <= '0;
            r_state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 4'd1;
          if (r_idx == IDX_W'(N_TAPS - 1)) begin
            r_result <= w_sum;
            r_valid  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Result stays put until the consumer acknowledges; the FIFO waits.
          if (result_ack) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_window_mac.sv
// Directed-vector bench for fir_window_mac with hand-computed expected results.
module tb_fir_window_mac;

  localparam int DATA_W = 11;
  localparam int COEF_W = 8;
  localparam int N_TAPS = 16;
  localparam int ACC_W  = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset;
  logic                      fifo_ready;
  logic [N_TAPS*DATA_W-1:0]  fifo_data;
  logic                      fifo_read;
  logic                      coef_we;
  logic [3:0]                coef_addr;
  logic [COEF_W-1:0]         coef_wdata;
  logic                      coef_busy;
  logic signed [ACC_W-1:0]   result;
  logic                      result_valid;
  logic                      result_ack;

  int checks = 0;
  int errors = 0;

  fir_window_mac dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_ready   (fifo_ready),
    .fifo_data    (fifo_data),
    .fifo_read    (fifo_read),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .coef_busy    (coef_busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ack   (result_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [7:0] v);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic fill_coefs(input logic [7:0] v);
    for (int k = 0; k < N_TAPS; k++) begin
      write_coef(k[3:0], v);
    end
  endtask

  task automatic fill_lanes(input logic [10:0] v);
    for (int k = 0; k < N_TAPS; k++) begin
      fifo_data[k*DATA_W +: DATA_W] = v;
    end
  endtask

  task automatic start_window();
    fifo_ready = 1'b1;
    tick();
    fifo_ready = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!result_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fifo_ready = 1'b0;
    fifo_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    result_ack = 1'b0;
    tick();
    tick();
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    checks++;
    if (result !== 23'sd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
    checks++;
    if (coef_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", coef_busy); end
    checks++;
    if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_fifo_read: got %b expected 0", fifo_read); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_boxcar();
    for (int k = 0; k < N_TAPS; k++) begin
      fifo_data[k*DATA_W +: DATA_W] = 11'(k + 1);
    end
    fifo_ready = 1'b1;
    #1;
    checks++;
    if (fifo_read !== 1'b1) begin errors++; $display("FAIL boxcar_read_high: got %b expected 1", fifo_read); end
    tick();
    checks++;
    if (fifo_read !== 1'b0) begin errors++; $display("FAIL boxcar_read_pulse: got %b expected 0", fifo_read); end
    checks++;
    if (coef_busy !== 1'b1) begin errors++; $display("FAIL boxcar_busy: got %b expected 1", coef_busy); end
    fifo_ready = 1'b0;
    repeat (15) tick();
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL boxcar_early_valid: got %b expected 0", result_valid); end
    tick();
    checks++;
    if (result_valid !== 1'b1) begin errors++; $display("FAIL boxcar_latency: got %b expected 1", result_valid); end
    checks++;
    if (result !== 23'sd136) begin errors++; $display("FAIL boxcar_result: got %0d expected 136", result); end
    ack();
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL boxcar_ack: got %b expected 0", result_valid); end
    checks++;
    if (result !== 23'sd136) begin errors++; $display("FAIL boxcar_result_kept: got %0d expected 136", result); end
  endtask

  task automatic test_negative_full();
    int n;
    fill_coefs(8'd127);
    fill_lanes(11'h400);
    start_window();
    wait_result(n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL neg_latency: got %0d expected 16", n); end
    checks++;
    if (result !== 23'h604000) begin errors++; $display("FAIL neg_result: got %h expected 604000", result); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (result_valid !== 1'b1 || result !== 23'h604000) begin
        errors++;
        $display("FAIL neg_hold: valid %b result %h expected 1/604000", result_valid, result);
      end
    end
    ack();
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL neg_ack: got %b expected 0", result_valid); end
  endtask

  task automatic test_single_tap();
    int n;
    logic signed [ACC_W-1:0] exp_val;
    exp_val = -23'sd300;
    fill_coefs(8'd0);
    for (int k = 0; k < N_TAPS; k++) begin
      fifo_data[k*DATA_W +: DATA_W] = 11'($urandom);
    end
    fifo_data[5*DATA_W +: DATA_W] = 11'd100;
    // coef[5] written on the capture edge itself
    fifo_ready = 1'b1;
    coef_we    = 1'b1;
    coef_addr  = 4'd5;
    coef_wdata = 8'hFD;
    tick();
    fifo_ready = 1'b0;
    coef_we    = 1'b0;
    wait_result(n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL tap_latency: got %0d expected 16", n); end
    checks++;
    if (result !== exp_val) begin errors++; $display("FAIL tap_result: got %0d expected -300", result); end
    ack();
  endtask

  task automatic test_backpressure();
    int n;
    fill_coefs(8'd1);
    fill_lanes(11'd3);
    start_window();
    wait_result(n);
    checks++;
    if (result_valid !== 1'b1 || result !== 23'sd48) begin
      errors++;
      $display("FAIL bp_result: valid %b result %0d expected 1/48", result_valid, result);
    end
    fifo_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (fifo_read !== 1'b0 || result !== 23'sd48 || result_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: read %b valid %b result %0d expected 0/1/48", fifo_read, result_valid, result);
      end
    end
    ack();
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL bp_ack_valid: got %b expected 0", result_valid); end
    checks++;
    if (fifo_read !== 1'b1) begin errors++; $display("FAIL bp_read_after_ack: got %b expected 1", fifo_read); end
    tick();
    fifo_ready = 1'b0;
    checks++;
    if (fifo_read !== 1'b0) begin errors++; $display("FAIL bp_read_pulse: got %b expected 0", fifo_read); end
    wait_result(n);
    checks++;
    if (result !== 23'sd48) begin errors++; $display("FAIL bp_second_result: got %0d expected 48", result); end
    ack();
  endtask

  task automatic test_busy_drop();
    int n;
    fill_lanes(11'd2);
    start_window();
    tick();
    tick();
    checks++;
    if (coef_busy !== 1'b1) begin errors++; $display("FAIL busy_flag: got %b expected 1", coef_busy); end
    write_coef(4'd0, 8'd50);
    wait_result(n);
    checks++;
    if (result !== 23'sd32) begin errors++; $display("FAIL busy_first: got %0d expected 32", result); end
    ack();
    start_window();
    wait_result(n);
    checks++;
    if (result_valid !== 1'b1 || result !== 23'sd32) begin
      errors++;
      $display("FAIL busy_dropped: valid %b result %0d expected 1/32", result_valid, result);
    end
    ack();
  endtask

  task automatic test_reset_mid_mac();
    int n;
    write_coef(4'd3, 8'd9);
    for (int k = 0; k < N_TAPS; k++) begin
      fifo_data[k*DATA_W +: DATA_W] = 11'(k + 1);
    end
    start_window();
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", result_valid); end
    checks++;
    if (result !== 23'sd0) begin errors++; $display("FAIL rst_mid_result: got %0d expected 0", result); end
    checks++;
    if (coef_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", coef_busy); end
    fifo_ready = 1'b1;
    #1;
    checks++;
    if (fifo_read !== 1'b1) begin errors++; $display("FAIL rst_mid_read: got %b expected 1", fifo_read); end
    fifo_ready = 1'b0;
    #1;
    checks++;
    if (fifo_read !== 1'b0) begin errors++; $display("FAIL rst_mid_read_low: got %b expected 0", fifo_read); end
    repeat (20) tick();
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_aborted: got %b expected 0", result_valid); end
    start_window();
    wait_result(n);
    checks++;
    if (result_valid !== 1'b1 || result !== 23'sd136) begin
      errors++;
      $display("FAIL rst_mid_coefs: valid %b result %0d expected 1/136", result_valid, result);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_boxcar();
    test_negative_full();
    test_single_tap();
    test_backpressure();
    test_busy_drop();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
